data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, width of data words and addresses.
REQ-002 The block SHALL have parameter DEPTH, default 32, number of RAM words at addresses 0..DEPTH-1.
REQ-003 The block SHALL have parameter WAIT_STATES, default 2, extra cycles per access, legal range 0..15.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port ALUResult, input, DATA_WIDTH bits: the processor's access address.
REQ-007 The block SHALL have port writeData, input, DATA_WIDTH bits: store data.
REQ-008 The block SHALL have port memWrite, input, 1 bit: store request.
REQ-009 The block SHALL have port memRead, input, 1 bit: load request.
REQ-010 The block SHALL have port readData, output, DATA_WIDTH bits: registered load data.
REQ-011 The block SHALL have port ready, output, 1 bit: access-complete strobe.
REQ-012 The block SHALL have port ioIn, input, DATA_WIDTH bits: external input port.
REQ-013 The block SHALL have port ioOut, output, DATA_WIDTH bits: registered output port.
REQ-014 The block SHALL have port err, output, 1 bit: sticky error flag for unmapped accesses.

Function
REQ-015 The block SHALL implement FSM states IDLE, WAIT, DONE.
REQ-016 In IDLE, memWrite or memRead high at an edge SHALL capture ALUResult, writeData and op (memWrite has priority when both are high), load cnt=WAIT_STATES and go to WAIT, or go directly to DONE if WAIT_STATES=0.
REQ-017 In WAIT, each edge SHALL decrement cnt; an edge with cnt==1 SHALL go to DONE.
REQ-018 The edge entering DONE SHALL perform the access using the captured values only.
REQ-019 In DONE, ready SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE unconditionally.
REQ-020 Latency: a request sampled at the end of cycle T SHALL give ready=1 in cycle T+WAIT_STATES+1.
REQ-021 Requests present while in WAIT or DONE SHALL be ignored; a request held high SHALL be re-sampled in IDLE, one cycle after DONE.
REQ-022 Address map SHALL be: 0..DEPTH-1 is RAM; 2^DATA_WIDTH-1 (0xFF) is ioOut, read/write; 2^DATA_WIDTH-2 (0xFE) is ioIn, read-only; all other addresses are unmapped.
REQ-023 A RAM write SHALL update the addressed word; a RAM read SHALL load the word into readData.
REQ-024 A write to 0xFF SHALL update ioOut; a read of 0xFF SHALL return ioOut.
REQ-025 A read of 0xFE SHALL return ioIn as sampled on the edge entering DONE; a write to 0xFE SHALL be ignored and SHALL set err.
REQ-026 An unmapped read SHALL load 0 into readData and set err; an unmapped write SHALL change no state except setting err.
REQ-027 readData SHALL change only on edges entering DONE for a read, and SHALL hold its value otherwise, including across writes.
REQ-028 Once set, err SHALL clear only on reset.
REQ-029 A read SHALL return data from every write whose DONE has completed, with no stale read-after-write.

Reset
REQ-030 While reset is high at an edge, the block SHALL set state=IDLE, cnt=0, ready=0, readData=0, ioOut=0, err=0; reset SHALL take priority over all other activity.
REQ-031 RAM contents SHALL NOT be cleared by reset.
REQ-032 Reset asserted during WAIT SHALL abort the access: no RAM/ioOut update, no ready pulse.
REQ-033 After reset deasserts, the first request SHALL be accepted from IDLE normally.

Verification
REQ-034 The bench SHALL cover write then read: WAIT_STATES=2, memWrite addr 5 data 0xA5 sampled end of cycle 10 -> ready=1 in cycle 13 only; memRead addr 5 -> readData=0xA5 with ready.
REQ-035 The bench SHALL cover zero-wait operation: WAIT_STATES=0, read addr 0 after writing 0x3C -> ready in the cycle immediately after sampling, readData=0x3C.
REQ-036 The bench SHALL cover I/O: write 0x81 to 0xFF -> ioOut=0x81 from the DONE cycle; ioIn=0x5A, read 0xFE -> readData=0x5A, err stays 0.
REQ-037 The bench SHALL cover unmapped/illegal access: read addr 0x40 -> readData=0, err=1; write 0xFE -> err stays 1, RAM and ioOut unchanged; err persists until reset.
REQ-038 The bench SHALL cover simultaneous request: memWrite=memRead=1, addr 7, data 0x11 -> treated as write, readData unchanged; a later read of 7 returns 0x11.
REQ-039 The bench SHALL cover reset mid-access: write addr 9 data 0xEE, reset in the first WAIT cycle -> no ready, ioOut=0, readData=0; a later read of 9 returns the pre-write value.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Wait-stated data memory controller: small RAM, one output port, one input port, sticky error.
// Each access takes WAIT_STATES+1 cycles and ends with a one-cycle ready strobe.
module data_mem_ctrl #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  memWrite,
  input  logic                  memRead,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  ready,
  input  logic [DATA_WIDTH-1:0] ioIn,
  output logic [DATA_WIDTH-1:0] ioOut,
  output logic                  err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_WIDTH-1:0] IO_OUT_ADDR = '1;
  localparam logic [DATA_WIDTH-1:0] IO_IN_ADDR  = {{(DATA_WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wr_q;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] ioout_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  req;
  logic                  fire;
  logic                  acc_wr;
  logic                  acc_ram;
  logic [DATA_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_data;
  logic [AW-1:0]         acc_idx;

  // With zero wait states the access happens on the sampling edge, so it uses the live inputs.
  always_comb begin
    req      = memWrite | memRead;
    fire     = ((state_q == IDLE) && req && (WAIT_STATES == 0)) ||
               ((state_q == WAIT) && (cnt_q == 4'd1));
    acc_addr = (state_q == IDLE) ? ALUResult : addr_q;
    acc_data = (state_q == IDLE) ? writeData : wdata_q;
    acc_wr   = (state_q == IDLE) ? memWrite  : wr_q;
    acc_ram  = 32'(acc_addr) < 32'(DEPTH);
    acc_idx  = acc_addr[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      ioout_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            addr_q  <= ALUResult;
            wdata_q <= writeData;
            wr_q    <= memWrite;
            cnt_q   <= 4'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              state_q <= DONE;
              ready_q <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= DONE;
            ready_q <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      // Address decode for the access completing on this edge.
      if (fire) begin
        if (acc_wr) begin
          if (!acc_ram) begin
            if (acc_addr == IO_OUT_ADDR) ioout_q <= acc_data;
            else                         err_q   <= 1'b1;
          end
        end else begin
          if (acc_ram)                       rdata_q <= mem_q[acc_idx];
          else if (acc_addr == IO_OUT_ADDR)  rdata_q <= ioout_q;
          else if (acc_addr == IO_IN_ADDR)   rdata_q <= ioIn;
          else begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
      end
    end
  end

  // RAM array keeps its contents through reset.
  always_ff @(posedge clk) begin
    if (!reset && fire && acc_wr && acc_ram) mem_q[acc_idx] <= acc_data;
  end

  assign readData = rdata_q;
  assign ready    = ready_q;
  assign ioOut    = ioout_q;
  assign err      = err_q;

endmodule
